// File: rtl/capture_ctrl.sv
// capture_ctrl: trigger-driven capture sequencer for the oscilloscope sample buffer.
// Keeps a programmable pre-trigger history in a circular RAM, then streams it out oldest-first.
//
// state | meaning
// IDLE  | waiting for arm
// FILL  | collecting the pre-trigger history, triggers ignored
// ARMED | circular writing, waiting for a qualified trigger sample
// POST  | writing the post-trigger remainder of the buffer
// READ  | streaming the capture out over valid/ready
module capture_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int MEM_SIZE   = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic                  sample_valid_i,
  input  logic                  trig_i,
  input  logic [ADDR_WIDTH-1:0] pre_trig_i,
  output logic                  ram_w_en_o,
  output logic [ADDR_WIDTH-1:0] ram_w_addr_o,
  output logic [ADDR_WIDTH-1:0] ram_r_addr_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  rd_last_o,
  output logic [ADDR_WIDTH-1:0] trig_addr_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READ} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH    = (ADDR_WIDTH + 1)'(MEM_SIZE);

  state_t state, state_d;

  logic [ADDR_WIDTH-1:0] wr_ptr, pre_q, fill_cnt, rd_cnt;
  logic [ADDR_WIDTH-1:0] pre_clamp, fill_cnt_inc;
  logic [ADDR_WIDTH:0]   post_cnt, post_cnt_inc, post_len;
  logic wr_state, do_arm, fill_ends, trig_hit, trig_ends, post_ends, rd_accept, rd_end;

  // DATA_WIDTH only documents the RAM word the addresses index; the clamp matters
  // only if the address field is wider than the buffer.
  if (MEM_SIZE < (1 << ADDR_WIDTH) && DATA_WIDTH > 0) begin : g_clamp
    assign pre_clamp = (pre_trig_i > ADDR_MAX) ? ADDR_MAX : pre_trig_i;
  end else begin : g_no_clamp
    assign pre_clamp = pre_trig_i;
  end

  always_comb begin
    fill_cnt_inc = fill_cnt + 1'b1;
    post_cnt_inc = post_cnt + 1'b1;
    post_len     = DEPTH - {1'b0, pre_q};
    wr_state     = (state == FILL) || (state == ARMED) || (state == POST);
    ram_w_en_o   = sample_valid_i && wr_state && !abort_i;
    do_arm       = (state == IDLE) && arm_i && !abort_i;
    fill_ends    = (state == FILL) && ram_w_en_o && (fill_cnt_inc == pre_q);
    trig_hit     = (state == ARMED) && ram_w_en_o && trig_i;
    trig_ends    = trig_hit && (post_len == (ADDR_WIDTH + 1)'(1));
    post_ends    = (state == POST) && ram_w_en_o && (post_cnt_inc == post_len);
    rd_accept    = (state == READ) && rd_ready_i && !abort_i;
    rd_end       = rd_accept && (rd_cnt == ADDR_MAX);

    state_d = state;
    case (state)
      IDLE:    if (arm_i) state_d = (pre_trig_i == '0) ? ARMED : FILL;
      FILL:    if (fill_ends) state_d = ARMED;
      ARMED:   if (trig_hit) state_d = trig_ends ? READ : POST;
      POST:    if (post_ends) state_d = READ;
      READ:    if (rd_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  assign ram_w_addr_o = wr_ptr;
  assign rd_valid_o   = (state == READ);
  assign rd_last_o    = (state == READ) && (rd_cnt == ADDR_MAX);
  assign busy_o       = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      pre_q        <= '0;
      fill_cnt     <= '0;
      post_cnt     <= '0;
      rd_cnt       <= '0;
      ram_r_addr_o <= '0;
      trig_addr_o  <= '0;
      done_o       <= 1'b0;
    end else begin
      state  <= state_d;
      done_o <= rd_end;

      if (do_arm) begin
        pre_q    <= pre_clamp;
        wr_ptr   <= '0;
        fill_cnt <= '0;
      end

      if (ram_w_en_o) wr_ptr <= wr_ptr + 1'b1;
      if ((state == FILL) && ram_w_en_o) fill_cnt <= fill_cnt_inc;

      // Trigger address comes from wr_ptr here: trig_addr_o is not yet updated.
      if (trig_hit) begin
        trig_addr_o <= wr_ptr;
        post_cnt    <= (ADDR_WIDTH + 1)'(1);
        if (trig_ends) begin
          ram_r_addr_o <= wr_ptr - pre_q;
          rd_cnt       <= '0;
        end
      end

      if ((state == POST) && ram_w_en_o) begin
        post_cnt <= post_cnt_inc;
        if (post_ends) begin
          ram_r_addr_o <= trig_addr_o - pre_q;
          rd_cnt       <= '0;
        end
      end

      if (rd_accept) begin
        ram_r_addr_o <= ram_r_addr_o + 1'b1;
        rd_cnt       <= rd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: table-driven and randomized captures against a sample-index model,
// plus hand sequences for abort and asynchronous reset.
module tb_capture_ctrl;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm_i, abort_i, sample_valid_i, trig_i, rd_ready_i;
  logic [AW-1:0] pre_trig_i;
  logic          ram_w_en_o, rd_valid_o, rd_last_o, busy_o, done_o;
  logic [AW-1:0] ram_w_addr_o, ram_r_addr_o, trig_addr_o;

  always #5 clk = ~clk;

  capture_ctrl #(.DATA_WIDTH(DW), .MEM_SIZE(N), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .arm_i(arm_i), .abort_i(abort_i),
    .sample_valid_i(sample_valid_i), .trig_i(trig_i), .pre_trig_i(pre_trig_i),
    .ram_w_en_o(ram_w_en_o), .ram_w_addr_o(ram_w_addr_o), .ram_r_addr_o(ram_r_addr_o),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_last_o(rd_last_o),
    .trig_addr_o(trig_addr_o), .busy_o(busy_o), .done_o(done_o)
  );

  // Sample buffer RAM: synchronous write, asynchronous read.
  logic [DW-1:0] tb_ram [N];
  logic [DW-1:0] sample_data;
  always @(posedge clk) if (ram_w_en_o) tb_ram[ram_w_addr_o] <= sample_data;

  int checks = 0;
  int failures = 0;
  int last_trig = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w_en"}, 32'(ram_w_en_o), 0);
    check({tag, "_w_addr"}, 32'(ram_w_addr_o), 0);
    check({tag, "_r_addr"}, 32'(ram_r_addr_o), 0);
    check({tag, "_rd_valid"}, 32'(rd_valid_o), 0);
    check({tag, "_rd_last"}, 32'(rd_last_o), 0);
    check({tag, "_trig_addr"}, 32'(trig_addr_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_done"}, 32'(done_o), 0);
  endtask

  typedef struct {
    int pre;
    int trig_idx;
    int valid_pct;
    int ready_pct;
    bit fill_trig;
    int stall_j;
    int exp_trig_addr;
    int exp_rd_start;
    int exp_writes;
  } vec_t;

  task automatic do_abort();
    abort_i = 1'b1;
    @(negedge clk); #1;
    abort_i = 1'b0;
  endtask

  // Caller is at negedge+1 with the DUT idle. Sample k of the capture goes to address k mod N;
  // the readout must be samples trig_idx-pre .. trig_idx-pre+N-1 in order.
  task automatic run_capture(input vec_t v);
    int k, j, budget, stall_cnt;
    logic [DW-1:0] base, exp_data;
    base = DW'($urandom_range(0, 3000));
    arm_i = 1'b1; pre_trig_i = AW'(v.pre);
    @(negedge clk); #1;
    arm_i = 1'b0;
    check("busy_after_arm", 32'(busy_o), 1);
    k = 0; budget = 0;
    while (!rd_valid_o) begin
      if (budget++ > 500) begin
        check("capture_timeout", 32'(budget), 0);
        do_abort();
        return;
      end
      sample_valid_i = ($urandom_range(1, 100) <= v.valid_pct);
      trig_i = sample_valid_i ?
               ((k == v.trig_idx) || ((k < v.pre || k > v.trig_idx) &&
                                      (v.fill_trig || $urandom_range(0, 1) == 1)))
             : ($urandom_range(0, 1) == 1);
      arm_i = ($urandom_range(0, 3) == 0);
      pre_trig_i = AW'($urandom_range(0, N - 1));
      sample_data = DW'(base + k);
      #1;
      check("w_en", 32'(ram_w_en_o), 32'(sample_valid_i));
      if (sample_valid_i) begin
        check("w_addr", 32'(ram_w_addr_o), k % N);
        k++;
      end
      @(negedge clk); #1;
    end
    sample_valid_i = 1'b0; trig_i = 1'b0; arm_i = 1'b0;
    check("writes", k, v.exp_writes);
    check("trig_addr", 32'(trig_addr_o), v.exp_trig_addr);
    check("rd_start", 32'(ram_r_addr_o), v.exp_rd_start);
    last_trig = v.exp_trig_addr;
    j = 0; budget = 0; stall_cnt = 0;
    while (j < N) begin
      if (budget++ > 200) begin
        check("readout_timeout", 32'(budget), 0);
        do_abort();
        return;
      end
      exp_data = DW'(base + v.trig_idx - v.pre + j);
      check("rd_valid", 32'(rd_valid_o), 1);
      check("rd_last", 32'(rd_last_o), 32'(j == N - 1));
      check("rd_data", 32'(tb_ram[ram_r_addr_o]), 32'(exp_data));
      check("rd_done_low", 32'(done_o), 0);
      if (j == v.stall_j && stall_cnt < 3) begin
        rd_ready_i = 1'b0;
        stall_cnt++;
      end else begin
        rd_ready_i = ($urandom_range(1, 100) <= v.ready_pct);
      end
      sample_valid_i = ($urandom_range(0, 1) == 1);
      #1;
      check("no_write_in_read", 32'(ram_w_en_o), 0);
      if (rd_ready_i) j++;
      @(negedge clk); #1;
    end
    rd_ready_i = 1'b0; sample_valid_i = 1'b0;
    check("done_pulse", 32'(done_o), 1);
    check("rd_valid_drop", 32'(rd_valid_o), 0);
    check("idle_after_read", 32'(busy_o), 0);
    @(negedge clk); #1;
    check("done_one_cycle", 32'(done_o), 0);
  endtask

  vec_t vecs[$];
  vec_t rv;

  initial begin
    rst = 1'b1;
    {arm_i, abort_i, sample_valid_i, trig_i, rd_ready_i} = '0;
    pre_trig_i = '0; sample_data = '0;
    @(negedge clk); #1;
    sample_valid_i = 1'b1; arm_i = 1'b1; #1;
    check_all_zero("reset");
    sample_valid_i = 1'b0; arm_i = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;

    //        pre trig vld rdy fill stall  taddr start writes
    vecs.push_back('{3, 5, 100, 100, 0, -1, 5, 2, 10});
    vecs.push_back('{0, 0, 100, 100, 0, -1, 0, 0, 8});
    vecs.push_back('{3, 4, 100, 100, 1, -1, 4, 1, 9});
    vecs.push_back('{3, 5, 100, 100, 0,  3, 5, 2, 10});
    vecs.push_back('{7, 7,  60, 100, 1, -1, 7, 0, 8});
    vecs.push_back('{7, 10, 70,  50, 0,  7, 2, 3, 11});
    vecs.push_back('{1, 9,  50,  40, 0,  0, 1, 0, 16});
    vecs.push_back('{5, 5,  50,  30, 1, -1, 5, 0, 8});
    vecs.push_back('{2, 13, 40,  60, 0,  4, 5, 3, 19});
    foreach (vecs[i]) run_capture(vecs[i]);

    for (int i = 0; i < 25; i++) begin
      rv.pre = $urandom_range(0, N - 1);
      rv.trig_idx = rv.pre + $urandom_range(0, 12);
      rv.valid_pct = $urandom_range(30, 100);
      rv.ready_pct = $urandom_range(30, 100);
      rv.fill_trig = 1'($urandom_range(0, 1));
      rv.stall_j = $urandom_range(0, N);
      rv.exp_trig_addr = rv.trig_idx % N;
      rv.exp_rd_start = (rv.trig_idx - rv.pre) % N;
      rv.exp_writes = rv.trig_idx + N - rv.pre;
      run_capture(rv);
    end

    // Abort in ARMED: the abort-cycle write is suppressed, no done, trigger address kept.
    arm_i = 1'b1; pre_trig_i = '0;
    @(negedge clk); #1;
    arm_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid_i = 1'b1; trig_i = 1'b0; #1;
      check("abort_seq_w_addr", 32'(ram_w_addr_o), i);
      @(negedge clk); #1;
    end
    sample_valid_i = 1'b1; trig_i = 1'b1; abort_i = 1'b1; #1;
    check("abort_no_write", 32'(ram_w_en_o), 0);
    @(negedge clk); #1;
    abort_i = 1'b0; sample_valid_i = 1'b0; trig_i = 1'b0;
    check("abort_idle", 32'(busy_o), 0);
    check("abort_no_done", 32'(done_o), 0);
    check("abort_trig_hold", 32'(trig_addr_o), last_trig);
    @(negedge clk); #1;
    check("abort_no_done_later", 32'(done_o), 0);

    // Asynchronous reset in POST, then a fresh capture must restart at address 0.
    arm_i = 1'b1; pre_trig_i = AW'(2);
    @(negedge clk); #1;
    arm_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_valid_i = 1'b1; trig_i = (i == 2);
      @(negedge clk); #1;
    end
    check("post_busy", 32'(busy_o), 1);
    check("post_trig_addr", 32'(trig_addr_o), 2);
    rst = 1'b1; #1;
    check_all_zero("async_rst");
    @(negedge clk); #1;
    rst = 1'b0; sample_valid_i = 1'b0; trig_i = 1'b0;
    arm_i = 1'b1; pre_trig_i = '0;
    @(negedge clk); #1;
    arm_i = 1'b0; sample_valid_i = 1'b1; #1;
    check("rearm_w_en", 32'(ram_w_en_o), 1);
    check("rearm_w_addr", 32'(ram_w_addr_o), 0);
    sample_valid_i = 1'b0;
    do_abort();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
